// File: rtl/irq_fifo_ctrl.sv
// rtl/irq_fifo_ctrl.sv - dual interrupt/address queue with processor pop port
module irq_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] irq_fifo_data,
    input  logic        irq_fifo_data_valid,
    input  logic        irq_fifo_irq_valid,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic        rd_ack,
    output logic [15:0] rd_data,
    output logic        data_irq,
    output logic        remote_irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    // Queue index 0 is the data queue, index 1 the remote-irq queue.
    logic [13:0]           mem       [2][DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr    [2];
    logic [DEPTH_LOG2-1:0] rd_ptr    [2];
    logic [DEPTH_LOG2:0]   count     [2];
    logic [DEPTH_LOG2:0]   count_nxt [2];
    logic                  ovf       [2];
    logic                  ovf_nxt   [2];

    logic [1:0] push;
    logic [1:0] pop_req;
    logic [1:0] do_pop;
    logic [1:0] do_push;
    logic [1:0] drop;
    logic [13:0] head;

    // Per-queue push/pop qualification, next count and sticky overflow update.
    always_comb begin
        push[0]    = irq_fifo_data_valid;
        push[1]    = irq_fifo_irq_valid;
        pop_req[0] = rd_req && !rd_sel;
        pop_req[1] = rd_req && rd_sel;
        for (int q = 0; q < 2; q++) begin
            do_pop[q]  = pop_req[q] && (count[q] != '0);
            // A full queue still accepts a push when the same cycle frees a slot.
            do_push[q] = push[q] && ((count[q] != FULL_CNT) || do_pop[q]);
            drop[q]    = push[q] && !do_push[q];
            count_nxt[q] = count[q];
            if (do_push[q] && !do_pop[q]) begin
                count_nxt[q] = count[q] + 1'b1;
            end else if (do_pop[q] && !do_push[q]) begin
                count_nxt[q] = count[q] - 1'b1;
            end
            // A new overflow in the reading cycle wins over the read-clear.
            ovf_nxt[q] = ovf[q];
            if (drop[q]) begin
                ovf_nxt[q] = 1'b1;
            end else if (pop_req[q]) begin
                ovf_nxt[q] = 1'b0;
            end
        end
        head = mem[rd_sel][rd_ptr[rd_sel]];
    end

    // Entry storage; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++) begin
            if (!reset && do_push[q]) begin
                mem[q][wr_ptr[q]] <= irq_fifo_data;
            end
        end
    end

    // Pointer, count and overflow state for both queues.
    always_ff @(posedge clk) begin
        for (int q = 0; q < 2; q++) begin
            if (reset) begin
                wr_ptr[q] <= '0;
                rd_ptr[q] <= '0;
                count[q]  <= '0;
                ovf[q]    <= 1'b0;
            end else begin
                if (do_push[q]) begin
                    wr_ptr[q] <= wr_ptr[q] + 1'b1;
                end
                if (do_pop[q]) begin
                    rd_ptr[q] <= rd_ptr[q] + 1'b1;
                end
                count[q] <= count_nxt[q];
                ovf[q]   <= ovf_nxt[q];
            end
        end
    end

    // Registered read response and level interrupts.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack     <= 1'b0;
            rd_data    <= 16'h0000;
            data_irq   <= 1'b0;
            remote_irq <= 1'b0;
        end else begin
            rd_ack     <= rd_req;
            data_irq   <= (count_nxt[0] != '0);
            remote_irq <= (count_nxt[1] != '0);
            if (rd_req) begin
                rd_data <= {do_pop[rd_sel], ovf[rd_sel],
                            do_pop[rd_sel] ? head : 14'h0000};
            end else begin
                rd_data <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_irq_fifo_ctrl.sv
// tb/tb_irq_fifo_ctrl.sv - directed self-checking bench for irq_fifo_ctrl
module tb_irq_fifo_ctrl;

    logic        clk;
    logic        reset;
    logic [13:0] irq_fifo_data;
    logic        irq_fifo_data_valid;
    logic        irq_fifo_irq_valid;
    logic        rd_req;
    logic        rd_sel;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        data_irq;
    logic        remote_irq;

    int total;
    int bad;

    irq_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .irq_fifo_data       (irq_fifo_data),
        .irq_fifo_data_valid (irq_fifo_data_valid),
        .irq_fifo_irq_valid  (irq_fifo_irq_valid),
        .rd_req              (rd_req),
        .rd_sel              (rd_sel),
        .rd_ack              (rd_ack),
        .rd_data             (rd_data),
        .data_irq            (data_irq),
        .remote_irq          (remote_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic dq, input logic iq, input logic [13:0] d);
        irq_fifo_data       = d;
        irq_fifo_data_valid = dq;
        irq_fifo_irq_valid  = iq;
        step();
        irq_fifo_data_valid = 1'b0;
        irq_fifo_irq_valid  = 1'b0;
    endtask

    task automatic rd(input logic sel, output logic ack, output logic [15:0] d);
        rd_req = 1'b1;
        rd_sel = sel;
        step();
        rd_req = 1'b0;
        ack = rd_ack;
        d   = rd_data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total++;
        if (rd_ack !== 1'b0 || rd_data !== 16'h0000 || data_irq !== 1'b0 || remote_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ack=%b data=%h dirq=%b rirq=%b required 0/0000/0/0",
                     rd_ack, rd_data, data_irq, remote_irq);
        end
    endtask

    task automatic test_basic_dq();
        logic ack;
        logic [15:0] d;
        logic [15:0] exp [3] = '{16'h8010, 16'h8011, 16'h8012};
        push(1'b1, 1'b0, 14'h0010);
        total++;
        if (data_irq !== 1'b1) begin
            bad++;
            $display("FAIL dq_irq_rise: got %b required 1", data_irq);
        end
        push(1'b1, 1'b0, 14'h0011);
        push(1'b1, 1'b0, 14'h0012);
        for (int i = 0; i < 3; i++) begin
            rd(1'b0, ack, d);
            total++;
            if (ack !== 1'b1 || d !== exp[i]) begin
                bad++;
                $display("FAIL dq_read%0d: ack=%b data=%h required 1/%h", i, ack, d, exp[i]);
            end
        end
        total++;
        if (data_irq !== 1'b0) begin
            bad++;
            $display("FAIL dq_irq_fall: got %b required 0", data_irq);
        end
        rd(1'b0, ack, d);
        total++;
        if (ack !== 1'b1 || d !== 16'h0000) begin
            bad++;
            $display("FAIL dq_empty_read: ack=%b data=%h required 1/0000", ack, d);
        end
        step();
        total++;
        if (rd_ack !== 1'b0 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL idle_response: ack=%b data=%h required 0/0000", rd_ack, rd_data);
        end
    endtask

    task automatic test_overflow();
        logic ack;
        logic [15:0] d;
        for (int i = 0; i < 17; i++) begin
            push(1'b0, 1'b1, 14'(i));
        end
        total++;
        if (remote_irq !== 1'b1) begin
            bad++;
            $display("FAIL iq_irq_rise: got %b required 1", remote_irq);
        end
        rd(1'b1, ack, d);
        total++;
        if (ack !== 1'b1 || d !== 16'hC000) begin
            bad++;
            $display("FAIL ovf_first_read: ack=%b data=%h required 1/c000", ack, d);
        end
        for (int i = 1; i < 16; i++) begin
            rd(1'b1, ack, d);
            total++;
            if (d !== (16'h8000 | 16'(i))) begin
                bad++;
                $display("FAIL ovf_read%0d: data=%h required %h", i, d, 16'h8000 | 16'(i));
            end
        end
        total++;
        if (remote_irq !== 1'b0) begin
            bad++;
            $display("FAIL iq_irq_fall: got %b required 0", remote_irq);
        end
        rd(1'b1, ack, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL ovf_cleared: data=%h required 0000", d);
        end
    endtask

    task automatic test_full_push_pop();
        logic ack;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 1'b1, 14'h0100 + 14'(i));
        end
        irq_fifo_data      = 14'h3FFF;
        irq_fifo_irq_valid = 1'b1;
        rd_req = 1'b1;
        rd_sel = 1'b1;
        step();
        irq_fifo_irq_valid = 1'b0;
        rd_req = 1'b0;
        total++;
        if (rd_ack !== 1'b1 || rd_data !== 16'h8100) begin
            bad++;
            $display("FAIL full_pushpop: ack=%b data=%h required 1/8100", rd_ack, rd_data);
        end
        for (int i = 1; i < 16; i++) begin
            rd(1'b1, ack, d);
            total++;
            if (d !== (16'h8100 + 16'(i))) begin
                bad++;
                $display("FAIL full_drain%0d: data=%h required %h", i, d, 16'h8100 + 16'(i));
            end
        end
        rd(1'b1, ack, d);
        total++;
        if (d !== 16'hBFFF) begin
            bad++;
            $display("FAIL full_last: data=%h required bfff", d);
        end
        rd(1'b1, ack, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL full_after: data=%h required 0000", d);
        end
    endtask

    task automatic test_both();
        logic ack;
        logic [15:0] d;
        push(1'b1, 1'b1, 14'h0ABC);
        total++;
        if (data_irq !== 1'b1 || remote_irq !== 1'b1) begin
            bad++;
            $display("FAIL both_irq: dirq=%b rirq=%b required 1/1", data_irq, remote_irq);
        end
        rd(1'b0, ack, d);
        total++;
        if (d !== 16'h8ABC) begin
            bad++;
            $display("FAIL both_dq: data=%h required 8abc", d);
        end
        rd(1'b1, ack, d);
        total++;
        if (d !== 16'h8ABC) begin
            bad++;
            $display("FAIL both_iq: data=%h required 8abc", d);
        end
    endtask

    task automatic test_empty_read_push();
        logic ack;
        logic [15:0] d;
        irq_fifo_data       = 14'h1234;
        irq_fifo_data_valid = 1'b1;
        rd_req = 1'b1;
        rd_sel = 1'b0;
        step();
        irq_fifo_data_valid = 1'b0;
        rd_req = 1'b0;
        total++;
        if (rd_ack !== 1'b1 || rd_data !== 16'h0000) begin
            bad++;
            $display("FAIL empty_no_bypass: ack=%b data=%h required 1/0000", rd_ack, rd_data);
        end
        rd(1'b0, ack, d);
        total++;
        if (d !== 16'h9234) begin
            bad++;
            $display("FAIL empty_stored: data=%h required 9234", d);
        end
    endtask

    task automatic test_wrap();
        logic ack;
        logic [15:0] d;
        logic [15:0] exp_q [$];
        logic [15:0] e;
        for (int i = 0; i < 20; i++) begin
            push(1'b1, 1'b0, 14'h0200 + 14'(i));
            exp_q.push_back(16'h8200 + 16'(i));
            if (i % 2 == 1) begin
                rd(1'b0, ack, d);
                e = exp_q.pop_front();
                total++;
                if (d !== e) begin
                    bad++;
                    $display("FAIL wrap_interleave%0d: data=%h required %h", i, d, e);
                end
            end
        end
        while (exp_q.size() > 0) begin
            rd(1'b0, ack, d);
            e = exp_q.pop_front();
            total++;
            if (d !== e) begin
                bad++;
                $display("FAIL wrap_drain: data=%h required %h", d, e);
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic ack;
        logic [15:0] d;
        push(1'b1, 1'b1, 14'h0055);
        push(1'b1, 1'b0, 14'h0056);
        rd_req = 1'b1;
        rd_sel = 1'b0;
        step();
        rd_req = 1'b0;
        reset = 1'b1;
        irq_fifo_data       = 14'h0077;
        irq_fifo_data_valid = 1'b1;
        step();
        reset = 1'b0;
        irq_fifo_data_valid = 1'b0;
        total++;
        if (rd_ack !== 1'b0 || rd_data !== 16'h0000 || data_irq !== 1'b0 || remote_irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_inflight: ack=%b data=%h dirq=%b rirq=%b required 0/0000/0/0",
                     rd_ack, rd_data, data_irq, remote_irq);
        end
        rd(1'b0, ack, d);
        total++;
        if (ack !== 1'b1 || d !== 16'h0000) begin
            bad++;
            $display("FAIL reset_dq_empty: ack=%b data=%h required 1/0000", ack, d);
        end
        rd(1'b1, ack, d);
        total++;
        if (ack !== 1'b1 || d !== 16'h0000) begin
            bad++;
            $display("FAIL reset_iq_empty: ack=%b data=%h required 1/0000", ack, d);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        irq_fifo_data       = '0;
        irq_fifo_data_valid = 1'b0;
        irq_fifo_irq_valid  = 1'b0;
        rd_req = 1'b0;
        rd_sel = 1'b0;
        test_reset();
        test_basic_dq();
        test_overflow();
        test_full_push_pop();
        test_both();
        test_empty_read_push();
        test_wrap();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_fifo_ctrl.md
IRQ_FIFO_CTRL -- requirements
Module: irq_fifo_ctrl

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, log2 of entries per queue (16).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-004 irq_fifo_data  in  14  SPM/config address to enqueue, from RX unit.
REQ-005 irq_fifo_data_valid  in  1  push irq_fifo_data into data queue (DQ).
REQ-006 irq_fifo_irq_valid  in  1  push irq_fifo_data into remote-irq queue (IQ).
REQ-007 rd_req  in  1  processor pop request, one cycle per request.
REQ-008 rd_sel  in  1  queue select for rd_req: 0 = DQ, 1 = IQ.
REQ-009 rd_ack  out  1  response strobe for rd_req.
REQ-010 rd_data  out  16  response: [15] valid, [14] overflow, [13:0] entry.
REQ-011 data_irq  out  1  level interrupt: DQ non-empty.
REQ-012 remote_irq  out  1  level interrupt: IQ non-empty.

Function
REQ-013 DQ and IQ SHALL each be independent circular buffers of 2^DEPTH_LOG2 x 14-bit entries, with write pointer, read pointer and (DEPTH_LOG2+1)-bit count.
REQ-014 Push on a queue SHALL write at the write pointer, increment it modulo depth, and increment count, when not full or when a pop on the same queue occurs in the same cycle.
REQ-015 Push to a full queue without a simultaneous pop SHALL be dropped, with pointers/count unchanged, and SHALL set that queue's sticky overflow flag.
REQ-016 data_valid and irq_valid both high SHALL push the same irq_fifo_data into both queues independently.
REQ-017 rd_req SHALL produce rd_ack exactly one cycle later; back-to-back rd_req every cycle SHALL be supported.
REQ-018 rd_req on a non-empty queue SHALL return the head entry with rd_data[15]=1, advance the read pointer modulo depth, and decrement count.
REQ-019 rd_req on an empty queue SHALL return rd_data[15]=1'b0 and [13:0]=0 with no state change; a push in the same cycle is stored, not bypassed.
REQ-020 rd_data[14] SHALL return the selected queue's overflow flag as sampled at rd_req, and the flag SHALL clear in that cycle unless a new overflow occurs in the same cycle (set wins).
REQ-021 When rd_ack=0, rd_data SHALL be 16'h0000.
REQ-022 Simultaneous push and pop on the same queue SHALL leave count unchanged and advance both pointers.
REQ-023 data_irq/remote_irq SHALL be registered, reflecting count!=0 after the edge's updates, i.e. asserting one cycle after the first push.
REQ-024 Pointers SHALL wrap from depth-1 to 0; count SHALL range 0..depth.

Reset
REQ-025 In a reset cycle all pointers, counts and overflow flags SHALL become 0; rd_ack, rd_data, data_irq, remote_irq SHALL be 0 next cycle.
REQ-026 Reset SHALL take precedence over push and rd_req in the same cycle; an in-flight response is discarded (rd_ack=0 after reset).

Verification
REQ-027 Push DQ 0x0010, 0x0011, 0x0012; rd_req sel=0 x3 -> rd_data 0x8010, 0x8011, 0x8012; 4th read -> 0x0000 with rd_ack=1; data_irq low after third pop.
REQ-028 Push 17 entries 0x0000..0x0010 to IQ -> 17th dropped; first read 0xC000, next reads 0x8001..0x800F, no overflow bit; remote_irq 1->0.
REQ-029 IQ full, same-cycle push 0x3FFF and pop -> pop returns head, no overflow, count stays 16, 0x3FFF read last.
REQ-030 Both valids high with data 0x0ABC -> DQ and IQ each yield 0x8ABC; data_irq and remote_irq both assert one cycle after push.
REQ-031 Push 20 entries with reads interleaved to exercise pointer wrap -> FIFO order preserved across wrap.
REQ-032 Reset asserted one cycle after rd_req on non-empty DQ -> rd_ack=0, all queues empty, data_irq=0, subsequent read returns valid=0.
